// File: rtl/id_ex_if.sv
// ID/EX stage bus bundle.
// Groups the decode-slot fields, pipeline control (stall/flush), the EX/MEM
// and MEM/WB forwarding sources and every EX-side output into one interface.
//   master : the surrounding pipeline (drives id_*, stall, flush, exmem_*,
//            memwb_*; observes hazard and ex_*/alu_*)
//   slave  : the id_ex_stage itself
// ex_ctrl / id_ctrl bit order: {branch, mem_read, mem_to_reg, mem_write,
// alu_src, reg_write}.
interface id_ex_if #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
);
  // Decode slot
  logic            id_valid;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic [2:0]      id_funct3;
  logic            id_funct7_5;
  logic [1:0]      id_alu_op;
  logic [5:0]      id_ctrl;

  // Pipeline control
  logic            stall;
  logic            flush;

  // Forwarding sources
  logic            exmem_reg_write;
  logic [RA_W-1:0] exmem_rd;
  logic [XLEN-1:0] exmem_result;
  logic            memwb_reg_write;
  logic [RA_W-1:0] memwb_rd;
  logic [XLEN-1:0] memwb_data;

  // EX-side outputs
  logic            hazard;
  logic            ex_valid;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] ex_store_data;
  logic [RA_W-1:0] ex_rd;
  logic [5:0]      ex_ctrl;

  modport master (
    output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_funct3, id_funct7_5, id_alu_op, id_ctrl,
           stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    input  hazard, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd, ex_ctrl
  );

  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_funct3, id_funct7_5, id_alu_op, id_ctrl,
           stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    output hazard, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd, ex_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand-select stage.
// Captures the decoded instruction each cycle, turns ALUOp/funct3/funct7[5]
// into the 4-bit ALU operation code, resolves EX/MEM and MEM/WB forwarding
// for both operands, and flags load-use hazards to decode/fetch.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset (loads a bubble)
//   bus      : id_ex_if slave modport (decode fields, stall/flush,
//              forwarding sources, EX outputs)
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic    clk,
  input  logic    reset_n,
  id_ex_if.slave  bus
);

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_OTHER = 4'b1100;

  localparam int CTRL_MEM_READ = 4;
  localparam int CTRL_ALU_SRC  = 1;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [5:0]      ctrl;
    logic [3:0]      alu_ctrl;
  } ex_regs_t;

  // A bubble is an all-zero slot whose ALU code is a harmless add.
  function automatic ex_regs_t bubble();
    ex_regs_t b;
    b          = '0;
    b.alu_ctrl = ALU_ADD;
    return b;
  endfunction

  function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [2:0] funct3,
                                            input logic       funct7_5);
    logic [3:0] code;
    case (alu_op)
      2'b00:   code = ALU_ADD;
      2'b01:   code = ALU_SUB;
      default: begin
        case (funct3)
          // funct7[5] selects sub only for R-type; I-type addi ignores it.
          3'b000:  code = (alu_op == 2'b10 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111:  code = ALU_AND;
          3'b110:  code = ALU_OR;
          default: code = ALU_OTHER;
        endcase
      end
    endcase
    return code;
  endfunction

  // EX/MEM is younger than MEM/WB, so it wins when both target the operand.
  // x0 is hard-wired zero and never forwards.
  function automatic logic [XLEN-1:0] forward(input logic [RA_W-1:0] src,
                                              input logic [XLEN-1:0] reg_data,
                                              input logic            exmem_we,
                                              input logic [RA_W-1:0] exmem_rd,
                                              input logic [XLEN-1:0] exmem_val,
                                              input logic            memwb_we,
                                              input logic [RA_W-1:0] memwb_rd,
                                              input logic [XLEN-1:0] memwb_val);
    logic [XLEN-1:0] v;
    if (exmem_we && exmem_rd != '0 && exmem_rd == src)
      v = exmem_val;
    else if (memwb_we && memwb_rd != '0 && memwb_rd == src)
      v = memwb_val;
    else
      v = reg_data;
    return v;
  endfunction

  ex_regs_t        ex_q, ex_d;
  logic            hazard;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Load-use: the load in EX cannot supply its data in time for the
  // instruction in decode. Held low during reset so a stale EX slot
  // cannot freeze the front end.
  assign hazard = reset_n
                & ex_q.valid
                & ex_q.ctrl[CTRL_MEM_READ]
                & (ex_q.rd != '0)
                & bus.id_valid
                & ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));

  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that
    // leaves it unassigned would infer a latch.
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = bubble();
    end else if (bus.stall) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = bubble();
    end else begin
      ex_d.valid    = bus.id_valid;
      ex_d.rs1_data = bus.id_rs1_data;
      ex_d.rs2_data = bus.id_rs2_data;
      ex_d.imm      = bus.id_imm;
      ex_d.rs1      = bus.id_rs1;
      ex_d.rs2      = bus.id_rs2;
      ex_d.rd       = bus.id_rd;
      ex_d.ctrl     = bus.id_ctrl;
      ex_d.alu_ctrl = alu_decode(bus.id_alu_op, bus.id_funct3, bus.id_funct7_5);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps every register updating from
    // pre-edge values regardless of process ordering.
    if (!reset_n) ex_q <= bubble();
    else          ex_q <= ex_d;
  end

  always_comb begin
    fwd_rs1 = forward(ex_q.rs1, ex_q.rs1_data,
                      bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                      bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data);
    fwd_rs2 = forward(ex_q.rs2, ex_q.rs2_data,
                      bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                      bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data);
  end

  assign bus.hazard        = hazard;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.alu_a         = fwd_rs1;
  assign bus.alu_b         = ex_q.ctrl[CTRL_ALU_SRC] ? ex_q.imm : fwd_rs2;
  assign bus.alu_ctrl      = ex_q.alu_ctrl;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_ctrl       = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_id_ex_stage;

  localparam int XLEN = 64;
  localparam int RA_W = 5;

  logic clk;
  logic reset_n;

  int checks   = 0;
  int failures = 0;

  id_ex_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of what the EX slot holds
  typedef struct {
    bit          valid;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  ctrl;
    logic [3:0]  alu;
  } slot_t;

  slot_t m;

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.rs1d = 0; s.rs2d = 0; s.imm = 0;
    s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.ctrl = 0; s.alu = 4'b0010;
    return s;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f7);
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0110;
    if (f3 == 3'd7) return 4'b0000;
    if (f3 == 3'd6) return 4'b0001;
    if (f3 != 3'd0) return 4'b1100;
    if (op == 2'd2 && f7) return 4'b0110;
    return 4'b0010;
  endfunction

  function automatic logic [63:0] ref_fwd(input logic [4:0] r, input logic [63:0] d);
    if (bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == r) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == r) return bus.memwb_data;
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0; bus.id_funct3 = 0;
    bus.id_funct7_5 = 0; bus.id_alu_op = 0; bus.id_ctrl = 0;
    bus.stall = 0; bus.flush = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [5:0] ctrl);
    bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd; bus.id_ctrl = ctrl;
  endtask

  // Check all outputs against the model at the falling edge, then advance
  // the model across the next rising edge. Returns 1 time unit after it.
  task automatic cycle();
    logic        hz;
    logic [63:0] fb;
    @(negedge clk);
    hz = reset_n && m.valid && m.ctrl[4] && m.rd != 0 && bus.id_valid &&
         (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
    fb = ref_fwd(m.rs2, m.rs2d);
    check("hazard",     bus.hazard, hz);
    check("ex_valid",   bus.ex_valid, m.valid);
    check("ex_rd",      bus.ex_rd, m.rd);
    check("ex_ctrl",    bus.ex_ctrl, m.ctrl);
    check("alu_ctrl",   bus.alu_ctrl, m.alu);
    check("alu_a",      bus.alu_a, ref_fwd(m.rs1, m.rs1d));
    check("alu_b",      bus.alu_b, m.ctrl[1] ? m.imm : fb);
    check("store_data", bus.ex_store_data, fb);
    if (!reset_n || bus.flush) begin
      m = empty_slot();
    end else if (bus.stall) begin
      m = m;
    end else if (hz) begin
      m = empty_slot();
    end else begin
      m.valid = bus.id_valid; m.rs1d = bus.id_rs1_data; m.rs2d = bus.id_rs2_data;
      m.imm = bus.id_imm; m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2; m.rd = bus.id_rd;
      m.ctrl = bus.id_ctrl;
      m.alu = ref_alu(bus.id_alu_op, bus.id_funct3, bus.id_funct7_5);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic decode_case(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                             input logic [3:0] exp, input string tag);
    bus.id_alu_op = op; bus.id_funct3 = f3; bus.id_funct7_5 = f7;
    cycle();
    check(tag, bus.alu_ctrl, exp);
  endtask

  localparam logic [5:0] LOAD_CTRL = 6'b011011;

  initial begin
    m = empty_slot();
    clear_inputs();
    reset_n = 0;
    bus.id_valid = 1; bus.id_ctrl = 6'h3F;

    // Reset with a live decode slot
    @(posedge clk); #1;
    cycle();
    cycle();
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_ex_ctrl",  bus.ex_ctrl, 0);
    check("rst_alu_ctrl", bus.alu_ctrl, 4'b0010);
    check("rst_hazard",   bus.hazard, 0);

    // ALU decode sweep
    reset_n = 1;
    clear_inputs();
    set_id(5'd1, 5'd2, 5'd3, 6'b000001);
    decode_case(2'b10, 3'b000, 1'b1, 4'b0110, "dec_r_sub");
    decode_case(2'b10, 3'b000, 1'b0, 4'b0010, "dec_r_add");
    decode_case(2'b10, 3'b111, 1'b0, 4'b0000, "dec_r_and");
    decode_case(2'b10, 3'b110, 1'b0, 4'b0001, "dec_r_or");
    decode_case(2'b10, 3'b100, 1'b0, 4'b1100, "dec_r_other");
    decode_case(2'b11, 3'b000, 1'b1, 4'b0010, "dec_i_addi");
    decode_case(2'b01, 3'b111, 1'b1, 4'b0110, "dec_branch");

    // Forwarding
    clear_inputs();
    set_id(5'd5, 5'd5, 5'd6, 6'b000001);
    bus.id_rs1_data = 64'h1; bus.id_rs2_data = 64'h2;
    cycle();
    bus.stall = 1;
    bus.exmem_reg_write = 1; bus.exmem_rd = 5; bus.exmem_result = 64'hAA;
    bus.memwb_reg_write = 1; bus.memwb_rd = 5; bus.memwb_data = 64'hBB;
    #1;
    check("fwd_exmem_a",     bus.alu_a, 64'hAA);
    check("fwd_exmem_store", bus.ex_store_data, 64'hAA);
    bus.exmem_reg_write = 0;
    #1;
    check("fwd_memwb_a", bus.alu_a, 64'hBB);
    bus.stall = 0;
    bus.id_ctrl = 6'b000011; bus.id_imm = 64'h10;
    cycle();
    check("fwd_imm_b",       bus.alu_b, 64'h10);
    check("fwd_memwb_store", bus.ex_store_data, 64'hBB);
    bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.memwb_rd = 0;
    #1;
    check("fwd_x0_a",     bus.alu_a, 64'h1);
    check("fwd_x0_store", bus.ex_store_data, 64'h2);

    // Load-use
    clear_inputs();
    set_id(5'd1, 5'd2, 5'd7, LOAD_CTRL);
    cycle();
    set_id(5'd3, 5'd7, 5'd9, 6'b000001);
    #1;
    check("lu_hazard", bus.hazard, 1);
    cycle();
    check("lu_bubble_valid", bus.ex_valid, 0);
    check("lu_bubble_ctrl",  bus.ex_ctrl, 0);
    set_id(5'd1, 5'd2, 5'd7, LOAD_CTRL);
    cycle();
    set_id(5'd8, 5'd8, 5'd9, 6'b000001);
    #1;
    check("lu_no_hazard", bus.hazard, 0);
    cycle();
    check("lu_no_hazard_cap", bus.ex_rd, 5'd9);

    // Hazard under stall: load held, bubble only once stall drops
    set_id(5'd1, 5'd2, 5'd7, LOAD_CTRL);
    cycle();
    set_id(5'd7, 5'd2, 5'd9, 6'b000001);
    bus.stall = 1;
    #1;
    check("prio_hazard", bus.hazard, 1);
    cycle();
    check("prio_hold_valid", bus.ex_valid, 1);
    check("prio_hold_rd",    bus.ex_rd, 5'd7);
    check("prio_hold_ctrl",  bus.ex_ctrl, LOAD_CTRL);
    bus.stall = 0;
    cycle();
    check("prio_bubble_valid", bus.ex_valid, 0);
    check("prio_bubble_ctrl",  bus.ex_ctrl, 0);
    cycle();
    check("prio_resume_rd", bus.ex_rd, 5'd9);

    // Stall freezes EX; flush beats stall; reset beats stall
    set_id(5'd4, 5'd4, 5'd12, 6'b100001);
    bus.id_alu_op = 2'b10; bus.id_funct3 = 3'b110;
    cycle();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.id_rd = 5'($urandom_range(13, 31));
      bus.id_ctrl = 6'($urandom);
      bus.id_funct3 = 3'($urandom);
      bus.id_rs1_data = {$urandom, $urandom};
      cycle();
      check("stall_rd",   bus.ex_rd, 5'd12);
      check("stall_ctrl", bus.ex_ctrl, 6'b100001);
      check("stall_alu",  bus.alu_ctrl, 4'b0001);
    end
    bus.flush = 1;
    cycle();
    check("flush_valid", bus.ex_valid, 0);
    check("flush_ctrl",  bus.ex_ctrl, 0);
    check("flush_alu",   bus.alu_ctrl, 4'b0010);
    bus.flush = 0;
    set_id(5'd1, 5'd2, 5'd7, LOAD_CTRL);
    cycle();
    set_id(5'd7, 5'd7, 5'd9, 6'b000001);
    reset_n = 0;
    #1;
    check("rst_hazard_mask", bus.hazard, 0);
    cycle();
    check("rst_stall_valid", bus.ex_valid, 0);
    reset_n = 1;
    bus.stall = 0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset_n              = ($urandom_range(0, 49) != 0);
      bus.stall            = ($urandom_range(0, 5) == 0);
      bus.flush            = ($urandom_range(0, 7) == 0);
      bus.id_valid         = ($urandom_range(0, 4) != 0);
      bus.id_rs1_data      = {$urandom, $urandom};
      bus.id_rs2_data      = {$urandom, $urandom};
      bus.id_imm           = {$urandom, $urandom};
      bus.id_rs1           = 5'($urandom_range(0, 7));
      bus.id_rs2           = 5'($urandom_range(0, 7));
      bus.id_rd            = 5'($urandom_range(0, 7));
      bus.id_funct3        = 3'($urandom);
      bus.id_funct7_5      = 1'($urandom);
      bus.id_alu_op        = 2'($urandom);
      bus.id_ctrl          = 6'($urandom);
      bus.exmem_reg_write  = 1'($urandom);
      bus.exmem_rd         = 5'($urandom_range(0, 7));
      bus.exmem_result     = {$urandom, $urandom};
      bus.memwb_reg_write  = 1'($urandom);
      bus.memwb_rd         = 5'($urandom_range(0, 7));
      bus.memwb_data       = {$urandom, $urandom};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
